rs_encoder: RTL and testbench

RS_ENCODER -- requirements
Module: rs_encoder

---
 rtl/rs_encoder.sv | 112 +++++++++++
 tb/tb_rs_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder.sv
// Systematic Reed-Solomon encoder over GF(2^8): streams message symbols through,
// then appends NSYM parity symbols from an LFSR-style remainder register.
module rs_encoder #(
    parameter int NSYM = 4,
    parameter int KMAX = 255 - NSYM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          prim_poly,
    input  logic [8*NSYM-1:0]   gen_flat,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                len_err
);
    localparam int CW = $clog2(KMAX + 1);
    localparam int PW = $clog2(NSYM);

    typedef enum logic {DATA, PARITY} state_t;
    state_t state, state_next;

    logic [7:0]    p    [NSYM];
    logic [7:0]    prod [NSYM];
    logic [CW-1:0] cnt;
    logic [PW-1:0] pcnt;
    logic          slot_free;
    logic          accept;
    logic          at_kmax;
    logic          final_sym;
    logic [7:0]    fb;

    // Shift-and-add GF(2^8) product, reduced by the programmable polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] poly);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ poly) : {x[6:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = !rst && (state == DATA) && slot_free;
        accept    = in_valid && in_ready;
        at_kmax   = (cnt == CW'(KMAX - 1));
        final_sym = in_last || at_kmax;
        fb        = in_data ^ p[NSYM-1];
        for (int unsigned k = 0; k < NSYM; k++) begin
            prod[k] = gf_mul(fb, gen_flat[8*k +: 8], prim_poly);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DATA:    if (accept && final_sym) state_next = PARITY;
            PARITY:  if (slot_free && pcnt == '0) state_next = DATA;
            default: state_next = DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DATA;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSYM; k++) p[k] <= '0;
            cnt       <= '0;
            pcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            len_err   <= 1'b0;
        end else if (state == DATA) begin
            if (accept) begin
                p[0] <= prod[0];
                for (int unsigned k = 1; k < NSYM; k++) p[k] <= p[k-1] ^ prod[k];
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                cnt       <= cnt + CW'(1);
                if (final_sym) pcnt <= PW'(NSYM - 1);
                if (at_kmax && !in_last) len_err <= 1'b1;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
        end else if (slot_free) begin
            // Parity drains from the top of the remainder register; zeros fill in
            // below so the register is clear once the codeword completes.
            out_data  <= p[NSYM-1];
            out_valid <= 1'b1;
            out_last  <= (pcnt == '0);
            for (int unsigned k = 1; k < NSYM; k++) p[k] <= p[k-1];
            p[0] <= '0;
            if (pcnt != '0) pcnt <= pcnt - PW'(1);
            else            cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: directed vectors plus randomized messages checked against a
// table-driven long-division model and codeword syndromes.
module tb_rs_encoder;
    localparam int NSYM = 4;
    localparam int KMAX = 255 - NSYM;
    localparam logic [8*NSYM-1:0] GEN = {8'h0F, 8'h36, 8'h78, 8'h40};

    logic              clk;
    logic              rst;
    logic [7:0]        prim_poly;
    logic [8*NSYM-1:0] gen_flat;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_ready;
    logic              len_err;

    rs_encoder #(.NSYM(NSYM), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .prim_poly(prim_poly), .gen_flat(gen_flat),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [7:0] sym_q_t [$];
    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       mid;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   gexp [256];
    int   glog [256];
    int   cw_done = 0;
    bit   rnd_ready = 1'b0;
    bit   gaps = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[(glog[a] + glog[b]) % 255]);
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic l, input logic mid);
        exp_t e;
        e.d = d;
        e.l = l;
        e.mid = mid;
        exp_q.push_back(e);
    endtask

    // Expected codeword by polynomial long division of m(x)*x^NSYM by monic g(x).
    task automatic push_model(input sym_q_t msg);
        logic [7:0] w [$];
        logic [7:0] g [NSYM+1];
        logic [8*NSYM-1:0] gv;
        logic [7:0] coef;
        int k;
        gv = GEN;
        k = msg.size();
        g[0] = 8'h01;
        for (int j = 1; j <= NSYM; j++) g[j] = gv[8*(NSYM-j) +: 8];
        w = msg;
        repeat (NSYM) w.push_back(8'h00);
        for (int i = 0; i < k; i++) begin
            coef = w[i];
            for (int j = 1; j <= NSYM; j++) w[i+j] = w[i+j] ^ gmul(coef, g[j]);
        end
        for (int i = 0; i < k; i++) push_exp(msg[i], 1'b0, 1'b0);
        for (int j = 0; j < NSYM; j++) push_exp(w[k+j], j == NSYM-1, j < NSYM-1);
    endtask

    task automatic push_const(input logic [7:0] m, input logic [7:0] p3, input logic [7:0] p2,
                              input logic [7:0] p1, input logic [7:0] p0);
        push_exp(m, 1'b0, 1'b0);
        push_exp(p3, 1'b0, 1'b1);
        push_exp(p2, 1'b0, 1'b1);
        push_exp(p1, 1'b0, 1'b1);
        push_exp(p0, 1'b1, 1'b0);
    endtask

    task automatic send_syms(input sym_q_t msg, input bit use_last);
        int n;
        bit acc;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = use_last && (i == msg.size() - 1);
            n = 0;
            acc = 1'b0;
            while (!acc && n < 300) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) begin
                check_eq("accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (cw_done == start && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("codeword_complete", 32'(cw_done - start), 32'd1);
        check_eq("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_cw(input sym_q_t msg, input bit use_last);
        int start;
        start = cw_done;
        push_model(msg);
        send_syms(msg, use_last);
        wait_done(start);
    endtask

    task automatic run_const(input logic [7:0] m, input logic [7:0] p3, input logic [7:0] p2,
                             input logic [7:0] p1, input logic [7:0] p0);
        sym_q_t q;
        int start;
        start = cw_done;
        q.push_back(m);
        push_const(m, p3, p2, p1, p0);
        send_syms(q, 1'b1);
        wait_done(start);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Output monitor: scoreboard order, stall stability, syndromes per codeword.
    initial begin
        logic [7:0] cw [$];
        logic [7:0] pd;
        logic [7:0] s;
        logic       pl;
        bit         ps;
        exp_t       h;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cw.delete();
                ps = 1'b0;
            end else begin
                if (ps) begin
                    check_eq("stall_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_data", 32'(out_data), 32'(pd));
                    check_eq("stall_last", 32'(out_last), 32'(pl));
                end
                if (out_valid && exp_q.size() > 0 && exp_q[0].mid)
                    check_eq("in_ready_parity", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_symbol", exp_q.size(), 1);
                    end else begin
                        h = exp_q.pop_front();
                        check_eq("out_data", 32'(out_data), 32'(h.d));
                        check_eq("out_last", 32'(out_last), 32'(h.l));
                    end
                    cw.push_back(out_data);
                    if (out_last) begin
                        for (int i = 0; i < NSYM; i++) begin
                            s = 8'h00;
                            foreach (cw[k]) s = gmul(s, 8'(gexp[i])) ^ cw[k];
                            check_eq($sformatf("syndrome%0d", i), 32'(s), 32'd0);
                        end
                        cw.delete();
                        cw_done++;
                    end
                end
                ps = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end
        end
    end

    initial begin
        sym_q_t m;
        int len;
        int n;
        int v;

        gexp[0] = 1;
        for (int i = 1; i < 255; i++) begin
            v = gexp[i-1] << 1;
            if ((v & 256) != 0) v = v ^ 'h11D;
            gexp[i] = v;
        end
        gexp[255] = 1;
        glog[0] = 0;
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;

        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out_ready = 1'b1;
        prim_poly = 8'h1D;
        gen_flat = GEN;

        #2 rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_len_err", 32'(len_err), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);

        run_const(8'h01, 8'h0F, 8'h36, 8'h78, 8'h40);
        run_const(8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80);
        run_const(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        rnd_ready = 1'b1;
        gaps = 1'b1;
        for (int t = 0; t < 8; t++) begin
            len = (t == 0) ? KMAX : (t == 1) ? 1 : (t == 2) ? KMAX - 1 : $urandom_range(2, 60);
            m.delete();
            repeat (len) m.push_back(8'($urandom));
            run_cw(m, 1'b1);
        end
        check_eq("len_err_clear", 32'(len_err), 32'd0);

        m.delete();
        repeat (KMAX) m.push_back(8'($urandom));
        run_cw(m, 1'b0);
        check_eq("len_err_set", 32'(len_err), 32'd1);
        m.delete();
        repeat (10) m.push_back(8'($urandom));
        run_cw(m, 1'b1);
        check_eq("len_err_sticky", 32'(len_err), 32'd1);

        rnd_ready = 1'b0;
        gaps = 1'b0;
        @(posedge clk); #1;
        m.delete();
        m.push_back(8'h01);
        push_const(8'h01, 8'h0F, 8'h36, 8'h78, 8'h40);
        send_syms(m, 1'b1);
        n = 0;
        while (!(out_valid && out_data == 8'h36) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("second_parity_seen", 32'(out_data), 32'h36);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_out_last", 32'(out_last), 32'd0);
        check_eq("midrst_out_data", 32'(out_data), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midrst_len_err", 32'(len_err), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_const(8'h01, 8'h0F, 8'h36, 8'h78, 8'h40);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
